// File: rtl/adder_operand_skew.sv
// Registers operand pairs and skews 2-bit slices so slice k reaches the slice-pipelined adder k cycles after slice 0.
// Latency: slice k appears k+1 cycles after accept; res_valid/res_tag appear STAGES+1 cycles after accept.
// Backpressure: none from the adder; in_ready drops only while flush is asserted.
module adder_operand_skew #(
    parameter int WIDTH  = 8,
    parameter int SLICE  = 2,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             flush,
    output logic             in_ready,
    output logic [WIDTH-1:0] skew_a,
    output logic [WIDTH-1:0] skew_b,
    output logic             skew_cin,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [2:0]       inflight
);

    logic             accept;
    logic [STAGES:0]  vld_pipe;
    logic [TAG_W-1:0] tag_pipe [0:STAGES];
    logic [TAG_W-1:0] tag_cnt;
    logic             cin_q;

    assign in_ready = ~flush;
    assign accept   = in_valid & in_ready;

    // Slice k gets a k+1 deep chain; bubbles shift zeros so idle slices read as 0.
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic [SLICE-1:0] a_pipe [0:k];
        logic [SLICE-1:0] b_pipe [0:k];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= k; i++) begin
                    a_pipe[i] <= '0;
                    b_pipe[i] <= '0;
                end
            end else if (flush) begin
                for (int i = 0; i <= k; i++) begin
                    a_pipe[i] <= '0;
                    b_pipe[i] <= '0;
                end
            end else begin
                a_pipe[0] <= accept ? in_a[SLICE*k +: SLICE] : '0;
                b_pipe[0] <= accept ? in_b[SLICE*k +: SLICE] : '0;
                for (int i = 1; i <= k; i++) begin
                    a_pipe[i] <= a_pipe[i-1];
                    b_pipe[i] <= b_pipe[i-1];
                end
            end
        end

        assign skew_a[SLICE*k +: SLICE] = a_pipe[k];
        assign skew_b[SLICE*k +: SLICE] = b_pipe[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cin_q    <= 1'b0;
            vld_pipe <= '0;
        end else if (flush) begin
            cin_q    <= 1'b0;
            vld_pipe <= '0;
        end else begin
            cin_q    <= accept & in_cin;
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
        end
    end

    // Tags are only meaningful alongside res_valid, so flush leaves this chain alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= STAGES; i++) begin
                tag_pipe[i] <= '0;
            end
            tag_cnt <= '0;
        end else begin
            tag_pipe[0] <= tag_cnt;
            for (int i = 1; i <= STAGES; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (accept) begin
                tag_cnt <= tag_cnt + TAG_W'(1);
            end
        end
    end

    // Accept and retire in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (flush) begin
            inflight <= '0;
        end else begin
            case ({accept, vld_pipe[STAGES]})
                2'b10:   inflight <= inflight + 3'd1;
                2'b01:   inflight <= inflight - 3'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign skew_cin  = cin_q;
    assign res_valid = vld_pipe[STAGES];
    assign res_tag   = tag_pipe[STAGES];

endmodule

// File: tb/tb_adder_operand_skew.sv
// Bench for adder_operand_skew: drives random operand streams into the skewer and a behavioural slice-pipelined adder.
module tb_adder_operand_skew;

    localparam int WIDTH  = 8;
    localparam int SLICE  = 2;
    localparam int STAGES = 4;
    localparam int TAG_W  = 4;
    localparam int N      = 1024;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             flush;
    logic             in_ready;
    logic [WIDTH-1:0] skew_a;
    logic [WIDTH-1:0] skew_b;
    logic             skew_cin;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic [2:0]       inflight;

    always #5 clk = ~clk;

    adder_operand_skew #(
        .WIDTH(WIDTH), .SLICE(SLICE), .STAGES(STAGES), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .flush(flush), .in_ready(in_ready), .skew_a(skew_a),
        .skew_b(skew_b), .skew_cin(skew_cin), .res_valid(res_valid),
        .res_tag(res_tag), .inflight(inflight)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference history: what was accepted at each edge and the last edge that discarded in-flight work.
    bit               hist     [N];
    logic [WIDTH-1:0] a_hist   [N];
    logic [WIDTH-1:0] b_hist   [N];
    bit               cin_hist [N];
    int               edge_n    = 0;
    int               last_kill = 0;
    logic [TAG_W-1:0] tag_model = '0;
    logic [WIDTH+TAG_W:0] sb[$];
    bit               mon_en  = 1'b0;
    int               max_inf = 0;

    function automatic bit acc_ok(input int c);
        return (c >= 1) && (c < N) && (c > last_kill) && hist[c];
    endfunction

    // Behavioural model of the downstream adder: stage j adds slice j with the carry of stage j-1.
    logic             st_c   [STAGES];
    logic [WIDTH-1:0] st_acc [STAGES];
    logic [SLICE:0]   ad_t;
    logic             ad_cj;
    logic [WIDTH-1:0] ad_prev;

    always @(posedge clk) begin
        for (int j = 0; j < STAGES; j++) begin
            if (j == 0) begin
                ad_cj   = skew_cin;
                ad_prev = '0;
            end else begin
                ad_cj   = st_c[j-1];
                ad_prev = st_acc[j-1];
            end
            ad_t = {1'b0, skew_a[SLICE*j +: SLICE]} + {1'b0, skew_b[SLICE*j +: SLICE]}
                 + (SLICE+1)'(ad_cj);
            st_c[j]   <= ad_t[SLICE];
            st_acc[j] <= ad_prev | (WIDTH'(ad_t[SLICE-1:0]) << (SLICE*j));
        end
    end

    task automatic cyc(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit c, input bit f);
        in_valid = v; in_a = a; in_b = b; in_cin = c; flush = f;
        #1 chk("in_ready", in_ready, 32'(!f));
        @(posedge clk);
        edge_n++;
        hist[edge_n]     = v && !f;
        a_hist[edge_n]   = a;
        b_hist[edge_n]   = b;
        cin_hist[edge_n] = c;
        if (f) begin
            last_kill = edge_n;
            sb.delete();
        end else if (v) begin
            sb.push_back({({1'b0, a} + {1'b0, b} + (WIDTH+1)'(c)), tag_model});
            tag_model++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic rnd_op();
        cyc(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_skew_a"}, skew_a, 0);
        chk({tag, "_skew_b"}, skew_b, 0);
        chk({tag, "_skew_cin"}, skew_cin, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_tag"}, res_tag, 0);
        chk({tag, "_inflight"}, inflight, 0);
    endtask

    // Monitor: compares every cycle against the history model and retires results from the scoreboard.
    logic [WIDTH-1:0]     m_ea, m_eb;
    int                   m_inf;
    logic [WIDTH+TAG_W:0] m_exp;

    always @(negedge clk) begin
        if (mon_en) begin
            m_ea = '0;
            m_eb = '0;
            for (int k = 0; k < STAGES; k++) begin
                if (acc_ok(edge_n - k)) begin
                    m_ea[SLICE*k +: SLICE] = a_hist[edge_n-k][SLICE*k +: SLICE];
                    m_eb[SLICE*k +: SLICE] = b_hist[edge_n-k][SLICE*k +: SLICE];
                end
            end
            chk("skew_a", skew_a, m_ea);
            chk("skew_b", skew_b, m_eb);
            chk("skew_cin", skew_cin, 32'(acc_ok(edge_n) && cin_hist[edge_n]));
            m_inf = 0;
            for (int c = edge_n - STAGES; c <= edge_n; c++) begin
                if (acc_ok(c)) m_inf++;
            end
            chk("inflight", inflight, m_inf);
            if (int'(inflight) > max_inf) max_inf = int'(inflight);
            chk("res_valid", res_valid, 32'(acc_ok(edge_n - STAGES)));
            if (res_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got result with empty scoreboard at %0t", $time);
                end else begin
                    m_exp = sb.pop_front();
                    chk("result", {st_c[STAGES-1], st_acc[STAGES-1]}, m_exp[WIDTH+TAG_W:TAG_W]);
                    chk("res_tag", res_tag, m_exp[TAG_W-1:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; flush = 1'b0;
        #3;
        chk_all_zero("reset");
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Single op: B5 + 6C + 1 = 0x122
        cyc(1'b1, 8'hB5, 8'h6C, 1'b1, 1'b0);
        idle(6);

        // Back-to-back throughput
        max_inf = 0;
        repeat (8) rnd_op();
        idle(6);
        chk("peak_inflight", max_inf, 5);

        // Bubbles: op, idle, op, idle, idle, op
        rnd_op(); idle(1); rnd_op(); idle(2); rnd_op();
        idle(6);

        // Flush mid-flight
        repeat (3) rnd_op();
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        rnd_op();
        idle(6);

        // Flush and in_valid on the same edge
        cyc(1'b1, 8'hFF, 8'h01, 1'b1, 1'b1);
        rnd_op();
        idle(6);

        // Async reset between edges with 4 ops in flight
        repeat (4) rnd_op();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        sb.delete();
        tag_model = '0;
        last_kill = edge_n;
        idle(2);
        rst_n = 1'b1;
        rnd_op();
        idle(6);

        // Random mix of ops, bubbles and flushes
        repeat (200) begin
            cyc(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom),
                1'($urandom), 1'($urandom_range(0, 15) == 0));
        end
        idle(7);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
